color_sensor_ctrl: RTL and testbench
====================================

COLOR_SENSOR_CTRL -- requirements
Module: color_sensor_ctrl

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, 7'h29, TCS3472 7-bit I2C address.
REQ-002 SHALL have parameter ATIME_VAL, 8'hD5, value written to ATIME register.
REQ-003 SHALL have parameter POWERUP_CYCLES, 125000, clk cycles waited after PON write.
REQ-004 SHALL have parameter INTEG_CYCLES, 5500000, clk cycles waited before each read burst.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, 500000, max clk cycles per I2C transaction.
REQ-006 SHALL have port clk  in  1  system clock.
REQ-007 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have port enable  in  1  level; high = run continuous measurement.
REQ-009 SHALL have port i2c_start  out  1  transaction request to I2C master (level).
REQ-010 SHALL have port i2c_rw  out  1  0 = write, 1 = read.
REQ-011 SHALL have port i2c_addr  out  7  always SLAVE_ADDR.
REQ-012 SHALL have port i2c_reg_addr  out  8  command byte (bit7 = 1 | register).
REQ-013 SHALL have port i2c_data_in  out  8  write data.
REQ-014 SHALL have port i2c_data_out  in  8  read data from I2C master.
REQ-015 SHALL have port i2c_done  in  1  I2C master completion, high one or more cycles.
REQ-016 SHALL have ports clear, red, green, blue  out  16 each  latest channel counts.
REQ-017 SHALL have port data_valid  out  1  one-cycle pulse when all four channels update.
REQ-018 SHALL have port busy  out  1  high in every state except IDLE.
REQ-019 SHALL have port timeout_err  out  1  sticky transaction timeout flag.

Function
REQ-020 SHALL implement states IDLE, PON_WR, PON_WAIT, AEN_WR, ATIME_WR, INTEG_WAIT, RD_XFER, PUBLISH.
REQ-021 SHALL move IDLE->PON_WR when enable=1; sequence PON_WR->PON_WAIT->AEN_WR->ATIME_WR->INTEG_WAIT->RD_XFER->PUBLISH.
REQ-022 SHALL write: PON_WR reg 0x80 data 0x01; AEN_WR reg 0x80 data 0x03; ATIME_WR reg 0x81 data ATIME_VAL; all with i2c_rw=0.
REQ-023 SHALL wait exactly POWERUP_CYCLES in PON_WAIT and INTEG_CYCLES in INTEG_WAIT, one shared 32-bit down-counter.
REQ-024 SHALL in RD_XFER issue 8 single-byte reads, index 0..7, i2c_rw=1, i2c_reg_addr = 8'h94 + index (CDATAL..BDATAH).
REQ-025 Handshake: i2c_start, i2c_rw, i2c_reg_addr, i2c_data_in SHALL be set in the same cycle and held stable until completion.
REQ-026 Completion SHALL be the rising edge of i2c_done (registered i2c_done_d); i2c_start SHALL drop the cycle after detection.
REQ-027 A new transaction SHALL NOT be issued while i2c_done is high.
REQ-028 On read completion, i2c_data_out SHALL be captured into an 8-byte shadow at the current index; byte order low then high per channel.
REQ-029 clear/red/green/blue SHALL change only in PUBLISH, all four simultaneously from the shadow; data_valid=1 for that single cycle.
REQ-030 After PUBLISH: enable=1 -> INTEG_WAIT; enable=0 -> IDLE.
REQ-031 enable falling mid-sequence SHALL let the current transaction or wait complete, then go to IDLE; an in-flight read burst SHALL be discarded (no PUBLISH).
REQ-032 Timeout: a per-transaction counter SHALL clear at issue; reaching TIMEOUT_CYCLES without completion SHALL drop i2c_start, set timeout_err, and go to PON_WR (enable=1) or IDLE (enable=0).
REQ-033 timeout_err SHALL clear only on reset or in a PUBLISH cycle.
REQ-034 Completion and timeout in the same cycle SHALL count as completion.
REQ-035 IDLE->PON_WR re-entry SHALL always redo full init (PON, AEN, ATIME).

Reset
REQ-036 rst=1 SHALL asynchronously force IDLE, i2c_start=0, i2c_rw=0, i2c_reg_addr=0, i2c_data_in=0, channel outputs=0, data_valid=0, busy=0, timeout_err=0, counters and shadow=0.
REQ-037 rst mid-transaction SHALL drop i2c_start immediately; i2c_addr is constant SLAVE_ADDR.

Verification (POWERUP_CYCLES=10, INTEG_CYCLES=20, TIMEOUT_CYCLES=50, I2C model done after 5 cycles)
REQ-038 enable=1 from reset -> writes (0x80,0x01),(0x80,0x03),(0x81,0xD5) in order, 10-cycle gap after first.
REQ-039 model returns bytes 0x11..0x88 for reads 0x94..0x9B -> clear=0x2211, red=0x4433, green=0x6655, blue=0x8877, one data_valid pulse.
REQ-040 model never asserts done on first read -> i2c_start drops 50 cycles after issue, timeout_err=1, restart at PON_WR; next PUBLISH clears timeout_err.
REQ-041 enable=0 during read index 3 -> index 3 completes, no data_valid, busy=0, outputs keep prior values.
REQ-042 model holds done high 4 cycles -> exactly one capture per transaction; no new i2c_start until done low.
REQ-043 rst pulse during RD_XFER -> all outputs zero same cycle; enable=1 after -> sequence restarts at PON_WR.

Source files
------------

// File: rtl/color_sensor_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | color_sensor_ctrl: TCS3472 init + continuous RGBC read sequencer over a  |
// | generic single-byte I2C master.            Revision: 1.0                 |
// +--------------------------------------------------------------------------+
module color_sensor_ctrl #(
  parameter logic [6:0]  SLAVE_ADDR     = 7'h29,
  parameter logic [7:0]  ATIME_VAL      = 8'hD5,
  parameter int unsigned POWERUP_CYCLES = 125000,
  parameter int unsigned INTEG_CYCLES   = 5500000,
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        i2c_start,
  output logic        i2c_rw,
  output logic [6:0]  i2c_addr,
  output logic [7:0]  i2c_reg_addr,
  output logic [7:0]  i2c_data_in,
  input  logic [7:0]  i2c_data_out,
  input  logic        i2c_done,
  output logic [15:0] clear,
  output logic [15:0] red,
  output logic [15:0] green,
  output logic [15:0] blue,
  output logic        data_valid,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_PON_WR     = 4'd1,
    S_PON_WAIT   = 4'd2,
    S_AEN_WR     = 4'd3,
    S_ATIME_WR   = 4'd4,
    S_INTEG_WAIT = 4'd5,
    S_RD_XFER    = 4'd6,
    S_PUBLISH    = 4'd7
  } state_t;

  localparam logic [31:0] c_PWR_LOAD   = 32'(POWERUP_CYCLES - 1);
  localparam logic [31:0] c_INTEG_LOAD = 32'(INTEG_CYCLES - 1);
  localparam logic [31:0] c_TO_LAST    = 32'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic        r_done_d;
  logic [31:0] r_wait_cnt;
  logic [31:0] r_to_cnt;
  logic [2:0]  r_idx;
  logic [7:0]  r_shadow [8];

  logic        w_done_rise;
  logic        w_xfer_state;
  logic        w_rw;
  logic [7:0]  w_reg;
  logic [7:0]  w_data;

  assign i2c_addr     = SLAVE_ADDR;
  assign busy         = (r_state != S_IDLE);
  assign w_done_rise  = i2c_done & ~r_done_d;
  assign w_xfer_state = (r_state == S_PON_WR) || (r_state == S_AEN_WR) ||
                        (r_state == S_ATIME_WR) || (r_state == S_RD_XFER);

  always_comb begin
    w_rw   = 1'b0;
    w_reg  = 8'h80;
    w_data = 8'h01;
    case (r_state)
      S_AEN_WR:   w_data = 8'h03;
      S_ATIME_WR: begin
        w_reg  = 8'h81;
        w_data = ATIME_VAL;
      end
      S_RD_XFER:  begin
        w_rw   = 1'b1;
        w_reg  = 8'h94 + {5'd0, r_idx};
        w_data = 8'h00;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_done_d     <= 1'b0;
      r_wait_cnt   <= '0;
      r_to_cnt     <= '0;
      r_idx        <= '0;
      i2c_start    <= 1'b0;
      i2c_rw       <= 1'b0;
      i2c_reg_addr <= '0;
      i2c_data_in  <= '0;
      clear        <= '0;
      red          <= '0;
      green        <= '0;
      blue         <= '0;
      data_valid   <= 1'b0;
      timeout_err  <= 1'b0;
      for (int i = 0; i < 8; i++) r_shadow[i] <= '0;
    end else begin
      r_done_d   <= i2c_done;
      data_valid <= 1'b0;
      if (w_xfer_state) begin
        if (!i2c_start) begin
          // Nothing in flight: a stale done must fall before the next issue.
          if (!enable) begin
            r_state <= S_IDLE;
          end else if (!i2c_done) begin
            i2c_start    <= 1'b1;
            i2c_rw       <= w_rw;
            i2c_reg_addr <= w_reg;
            i2c_data_in  <= w_data;
            r_to_cnt     <= '0;
          end
        end else if (w_done_rise) begin
          i2c_start <= 1'b0;
          if (r_state == S_RD_XFER) begin
            r_shadow[r_idx] <= i2c_data_out;
            r_idx           <= r_idx + 3'd1;
          end
          if (!enable) begin
            r_state <= S_IDLE;
          end else begin
            case (r_state)
              S_PON_WR: begin
                r_state    <= S_PON_WAIT;
                r_wait_cnt <= c_PWR_LOAD;
              end
              S_AEN_WR:   r_state <= S_ATIME_WR;
              S_ATIME_WR: begin
                r_state    <= S_INTEG_WAIT;
                r_wait_cnt <= c_INTEG_LOAD;
              end
              default: begin
                // Final byte goes straight to the outputs alongside the shadow.
                if (r_idx == 3'd7) begin
                  r_state     <= S_PUBLISH;
                  clear       <= {r_shadow[1], r_shadow[0]};
                  red         <= {r_shadow[3], r_shadow[2]};
                  green       <= {r_shadow[5], r_shadow[4]};
                  blue        <= {i2c_data_out, r_shadow[6]};
                  data_valid  <= 1'b1;
                  timeout_err <= 1'b0;
                end
              end
            endcase
          end
        end else if (r_to_cnt == c_TO_LAST) begin
          i2c_start   <= 1'b0;
          timeout_err <= 1'b1;
          r_state     <= enable ? S_PON_WR : S_IDLE;
        end else begin
          r_to_cnt <= r_to_cnt + 32'd1;
        end
      end else begin
        case (r_state)
          S_IDLE: if (enable) r_state <= S_PON_WR;
          S_PON_WAIT, S_INTEG_WAIT: begin
            if (r_wait_cnt == 32'd0) begin
              r_idx <= '0;
              if (!enable)                     r_state <= S_IDLE;
              else if (r_state == S_PON_WAIT)  r_state <= S_AEN_WR;
              else                             r_state <= S_RD_XFER;
            end else begin
              r_wait_cnt <= r_wait_cnt - 32'd1;
            end
          end
          S_PUBLISH: begin
            if (enable) begin
              r_state    <= S_INTEG_WAIT;
              r_wait_cnt <= c_INTEG_LOAD;
            end else begin
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_color_sensor_ctrl.sv
`default_nettype none
// Scoreboard bench for color_sensor_ctrl: I2C slave model with reference
// byte-to-channel mapping, monitor compares every data_valid publish.
module tb_color_sensor_ctrl;
  localparam int c_PWR = 10, c_INTEG = 20, c_TO = 50, c_DLY = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        i2c_start, i2c_rw;
  logic [6:0]  i2c_addr;
  logic [7:0]  i2c_reg_addr, i2c_data_in;
  logic [7:0]  i2c_data_out;
  logic        i2c_done;
  logic [15:0] clear, red, green, blue;
  logic        data_valid, busy, timeout_err;

  always #5 clk = ~clk;

  color_sensor_ctrl #(
    .SLAVE_ADDR(7'h29), .ATIME_VAL(8'hD5), .POWERUP_CYCLES(c_PWR),
    .INTEG_CYCLES(c_INTEG), .TIMEOUT_CYCLES(c_TO)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .i2c_start(i2c_start), .i2c_rw(i2c_rw), .i2c_addr(i2c_addr),
    .i2c_reg_addr(i2c_reg_addr), .i2c_data_in(i2c_data_in),
    .i2c_data_out(i2c_data_out), .i2c_done(i2c_done),
    .clear(clear), .red(red), .green(green), .blue(blue),
    .data_valid(data_valid), .busy(busy), .timeout_err(timeout_err)
  );

  typedef struct packed { logic rw; logic [7:0] rg; logic [7:0] dat; } txn_t;
  typedef struct packed { logic [15:0] c, r, g, b; } chan_t;

  int     errors = 0, checks = 0, dv_count = 0;
  txn_t   txn_log [$];
  int     issue_cyc [$];
  int     done_cyc [$];
  chan_t  sb [$];
  logic [7:0] rd_byte [8];
  logic [7:0] burst [8];
  logic [7:0] got;
  logic [7:0] last_done_reg = 8'h00;
  int     done_len = 1;
  bit     rand_bytes = 0;
  bit     no_done_next_read = 0;
  bit     to_seen = 0;
  int     to_len = 0, to_idx = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int cyc_now();
    return int'($time / 10);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_dv(input int target, input int budget, input string nm);
    int n = 0;
    while (dv_count < target && n < budget) begin tick(1); n++; end
    chk({nm, "_publish_reached"}, 32'(dv_count >= target), 1);
  endtask

  task automatic wait_txn(input int from_sz, input logic [7:0] rg, input int budget, input string nm);
    int n = 0;
    while (!(txn_log.size() > from_sz && txn_log[$].rg == rg) && n < budget) begin tick(1); n++; end
    chk({nm, "_txn_seen"}, 32'(txn_log.size() > from_sz && txn_log[$].rg == rg), 1);
  endtask

  task automatic wait_new(input int from_sz, input int budget, input string nm);
    int n = 0;
    while (txn_log.size() <= from_sz && n < budget) begin tick(1); n++; end
    chk({nm, "_new_txn"}, 32'(txn_log.size() > from_sz), 1);
  endtask

  // I2C slave model: done 5 cycles after issue, held done_len cycles.
  initial begin : i2c_model
    txn_t t;
    bit ok, stable;
    int n, ri;
    logic en_c;
    i2c_done = 1'b0;
    i2c_data_out = 8'h00;
    got = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (i2c_start && !i2c_done) begin
        t = '{rw: i2c_rw, rg: i2c_reg_addr, dat: i2c_data_in};
        txn_log.push_back(t);
        issue_cyc.push_back(cyc_now());
        ri = int'(t.rg) - 'h94;
        if (t.rw && ri == 0 && rand_bytes)
          foreach (rd_byte[i]) rd_byte[i] = 8'($urandom);
        if (t.rw && no_done_next_read) begin
          no_done_next_read = 0;
          n = 0;
          while (i2c_start && n < 200) begin @(posedge clk); #1; n++; end
          to_len = n;
          to_idx = txn_log.size();
          to_seen = 1;
        end else begin
          ok = 1; stable = 1;
          for (int k = 0; k < c_DLY && ok; k++) begin
            @(posedge clk); #1;
            if (!i2c_start) ok = 0;
            else if (i2c_rw !== t.rw || i2c_reg_addr !== t.rg || i2c_data_in !== t.dat) stable = 0;
          end
          if (ok) begin
            chk("hold_stable", 32'(stable), 1);
            i2c_data_out = (t.rw && ri >= 0 && ri < 8) ? rd_byte[ri[2:0]] : 8'h00;
            i2c_done = 1'b1;
            for (int k = 0; k < done_len; k++) begin
              @(posedge clk);
              if (k == 0) begin
                en_c = enable;
                done_cyc.push_back(cyc_now());
                last_done_reg = t.rg;
                if (t.rw && ri >= 0 && ri < 8) begin
                  burst[ri[2:0]] = i2c_data_out;
                  got = (ri == 0) ? 8'h01 : (got | (8'h01 << ri));
                  if (ri == 7 && got == 8'hFF && en_c && !rst)
                    sb.push_back('{c: {burst[1], burst[0]}, r: {burst[3], burst[2]},
                                   g: {burst[5], burst[4]}, b: {burst[7], burst[6]}});
                end
              end
              #1;
              chk("no_start_while_done", 32'(i2c_start), 0);
            end
            i2c_done = 1'b0;
          end
        end
      end
    end
  end

  initial begin : monitor
    chan_t e;
    logic pdv = 1'b0;
    forever begin
      @(negedge clk);
      if (data_valid) begin
        chk("dv_single_cycle", 32'(pdv), 0);
        dv_count++;
        chk("sb_has_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("clear", 32'(clear), 32'(e.c));
          chk("red",   32'(red),   32'(e.r));
          chk("green", 32'(green), 32'(e.g));
          chk("blue",  32'(blue),  32'(e.b));
        end
      end
      pdv = data_valid;
    end
  end

  initial begin : main
    int lsz, gap, dv0;
    logic [15:0] s_c, s_r, s_g, s_b;
    foreach (rd_byte[i]) rd_byte[i] = 8'(8'h11 * (i + 1));
    tick(3);
    chk("rst_start", 32'(i2c_start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_clear", 32'(clear), 0);
    chk("rst_blue", 32'(blue), 0);
    chk("rst_dv", 32'(data_valid), 0);
    chk("rst_to_err", 32'(timeout_err), 0);
    chk("rst_reg_addr", 32'(i2c_reg_addr), 0);
    chk("i2c_addr", 32'(i2c_addr), 32'h29);
    rst = 1'b0;
    tick(2);

    // Init writes and fixed-pattern first burst
    enable = 1'b1;
    wait_dv(1, 1500, "first");
    chk("log_len", 32'(txn_log.size() >= 11), 1);
    if (txn_log.size() >= 11) begin
      chk("wr0", 32'(txn_log[0]), 32'({1'b0, 8'h80, 8'h01}));
      chk("wr1", 32'(txn_log[1]), 32'({1'b0, 8'h80, 8'h03}));
      chk("wr2", 32'(txn_log[2]), 32'({1'b0, 8'h81, 8'hD5}));
      for (int i = 0; i < 8; i++) begin
        chk("rd_reg", 32'(txn_log[3 + i].rg), 32'(8'h94 + i));
        chk("rd_rw", 32'(txn_log[3 + i].rw), 1);
      end
      gap = issue_cyc[1] - done_cyc[0];
      chk("pon_gap", 32'(gap >= c_PWR && gap <= c_PWR + 2), 1);
      gap = issue_cyc[3] - done_cyc[2];
      chk("integ_gap", 32'(gap >= c_INTEG && gap <= c_INTEG + 2), 1);
    end
    chk("fixed_clear", 32'(clear), 32'h2211);
    chk("fixed_red", 32'(red), 32'h4433);
    chk("fixed_green", 32'(green), 32'h6655);
    chk("fixed_blue", 32'(blue), 32'h8877);

    // Random bursts
    rand_bytes = 1;
    wait_dv(dv_count + 3, 1500, "random");

    // Done held 4 cycles
    done_len = 4;
    wait_dv(dv_count + 2, 1500, "long_done");
    done_len = 1;

    // Enable drop during read index 3
    lsz = txn_log.size();
    wait_txn(lsz, 8'h97, 500, "idx3");
    enable = 1'b0;
    s_c = clear; s_r = red; s_g = green; s_b = blue;
    dv0 = dv_count;
    lsz = 0;
    while (busy && lsz < 100) begin tick(1); lsz++; end
    tick(30);
    chk("drop_busy", 32'(busy), 0);
    chk("drop_no_dv", 32'(dv_count), 32'(dv0));
    chk("drop_idx3_done", 32'(last_done_reg), 32'h97);
    chk("drop_last_txn", 32'(txn_log[$].rg), 32'h97);
    chk("drop_keep", 32'({s_c, s_r, s_g, s_b} == {clear, red, green, blue}), 1);

    // Timeout on first read, full re-init afterwards
    lsz = txn_log.size();
    no_done_next_read = 1;
    enable = 1'b1;
    wait_new(lsz, 50, "reinit");
    chk("reinit_pon", 32'(txn_log[lsz]), 32'({1'b0, 8'h80, 8'h01}));
    lsz = 0;
    while (!to_seen && lsz < 800) begin tick(1); lsz++; end
    chk("timeout_seen", 32'(to_seen), 1);
    chk("timeout_len", 32'(to_len), 32'(c_TO));
    chk("timeout_err_set", 32'(timeout_err), 1);
    wait_new(to_idx, 50, "after_to");
    if (txn_log.size() > to_idx)
      chk("after_to_pon", 32'(txn_log[to_idx]), 32'({1'b0, 8'h80, 8'h01}));
    chk("timeout_err_sticky", 32'(timeout_err), 1);
    wait_dv(dv_count + 1, 1500, "after_to");
    chk("timeout_err_cleared", 32'(timeout_err), 0);

    // Async reset during a read burst
    lsz = txn_log.size();
    wait_txn(lsz, 8'h96, 500, "pre_rst");
    #2 rst = 1'b1;
    #1;
    chk("arst_start", 32'(i2c_start), 0);
    chk("arst_chan", 32'({clear, red, green, blue}), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_reg", 32'(i2c_reg_addr), 0);
    tick(2);
    lsz = txn_log.size();
    rst = 1'b0;
    wait_new(lsz, 50, "post_rst");
    if (txn_log.size() > lsz)
      chk("post_rst_pon", 32'(txn_log[lsz]), 32'({1'b0, 8'h80, 8'h01}));
    wait_dv(dv_count + 1, 1500, "post_rst");

    enable = 1'b0;
    tick(120);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
